// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode map, FSM state type and opcode helpers for alu_seq.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ILL0 = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_MUL  = 4'h3,
    OP_DIV  = 4'h4,
    OP_MOD  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_NOT  = 4'h9,
    OP_NAND = 4'hA,
    OP_NOR  = 4'hB,
    OP_XNOR = 4'hC,
    OP_SHL  = 4'hD,
    OP_SHR  = 4'hE,
    OP_ILLF = 4'hF
  } alu_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    DIVIDE = 1'b1
  } state_e;

  // DIV and MOD go through the iterative divider (unless the divisor is zero)
  function automatic logic is_multicycle(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_div.sv
// alu_seq_div: iterative restoring unsigned divider, one quotient bit per cycle.
// i_start loads the operands; o_done pulses during the final iteration and
// o_quotient/o_remainder carry that iteration's results in the same cycle.
module alu_seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // r_quo starts as the dividend; its MSB feeds the partial remainder while
  // quotient bits enter at the LSB, so after WIDTH steps it holds the quotient.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_ge      = ~w_trial[WIDTH];
  assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  assign o_done      = r_busy & (r_cnt == '0);
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;

  // Load on start, then one restoring step per cycle until the count expires
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(WIDTH - 1);
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dvs  <= i_divisor;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked unsigned ALU with an iterative DIV/MOD path.
// Optional feature macro ALU_SEQ_FLAGS_EN adds a registered flags[3:0]
// output = {Z, N, C, V}.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             ERR_out
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int SHW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  alu_op_e          w_op;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_b_zero;
  logic             w_div_start;
  logic             w_div_done;
  logic             w_single_load;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             r_div_mod;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH-1:0]   w_res;
  logic               w_err;

  logic [WIDTH-1:0] r_c;
  logic             r_err;
  logic             r_valid;

  assign w_op          = alu_op_e'(opcode);
  assign w_b_zero      = (B == '0);
  assign w_in_ready    = (r_state == IDLE) & ~reset & (~r_valid | out_ready);
  assign w_accept      = in_valid & w_in_ready;
  assign w_div_start   = w_accept & is_multicycle(w_op) & ~w_b_zero;
  assign w_single_load = w_accept & ~w_div_start;

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign C         = r_c;
  assign ERR_out   = r_err;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};
  assign w_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign w_sh   = B[SHW-1:0];

  alu_seq_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_start     (w_div_start),
    .i_dividend  (A),
    .i_divisor   (B),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: leave IDLE only for a real divide, return when it finishes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_div_start) w_state_nxt = DIVIDE;
      DIVIDE:  if (w_div_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Single-cycle datapath; DIV/MOD entries here only ever land for B==0
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (w_op)
      OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_err = w_sum[WIDTH];        end
      OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_err = w_diff[WIDTH];       end
      OP_MUL:  begin w_res = w_prod[WIDTH-1:0]; w_err = |w_prod[2*WIDTH-1:WIDTH]; end
      OP_DIV:  begin w_res = '1;                w_err = 1'b1;                end
      OP_MOD:  begin w_res = A;                 w_err = 1'b1;                end
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NOT:  w_res = ~A;
      OP_NAND: w_res = ~(A & B);
      OP_NOR:  w_res = ~(A | B);
      OP_XNOR: w_res = ~(A ^ B);
      OP_SHL:  w_res = A << w_sh;
      OP_SHR:  w_res = A >> w_sh;
      default: begin w_res = '0; w_err = 1'b1; end
    endcase
  end

  // Remember which divider output the pending divide wants
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_mod <= 1'b0;
    end else if (w_div_start) begin
      r_div_mod <= (w_op == OP_MOD);
    end
  end

  // Output register: a new result overrides a same-cycle consume, so
  // out_valid stays high for back-to-back single-cycle ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_c     <= '0;
      r_err   <= 1'b0;
    end else if (w_div_done) begin
      r_valid <= 1'b1;
      r_c     <= r_div_mod ? w_rem : w_quo;
      r_err   <= 1'b0;
    end else if (w_single_load) begin
      r_valid <= 1'b1;
      r_c     <= w_res;
      r_err   <= w_err;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [WIDTH:0] w_shl_ext;
  logic [WIDTH:0] w_shr_ext;
  logic           w_cf;
  logic           w_vf;
  logic [3:0]     r_flags;

  // One extra bit on each side captures the last bit shifted out
  assign w_shl_ext = {1'b0, A} << w_sh;
  assign w_shr_ext = {A, 1'b0} >> w_sh;

  // Carry and signed-overflow flags for the single-cycle path
  always_comb begin
    w_cf = 1'b0;
    w_vf = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_cf = w_sum[WIDTH];
        w_vf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_cf = w_diff[WIDTH];
        w_vf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SHL:  w_cf = w_shl_ext[WIDTH];
      OP_SHR:  w_cf = w_shr_ext[0];
      default: ;
    endcase
  end

  // Flags register tracks the output register load conditions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (w_div_done) begin
      if (r_div_mod) begin
        r_flags <= {(w_rem == '0), w_rem[WIDTH-1], 2'b00};
      end else begin
        r_flags <= {(w_quo == '0), w_quo[WIDTH-1], 2'b00};
      end
    end else if (w_single_load) begin
      r_flags <= {(w_res == '0), w_res[WIDTH-1], w_cf, w_vf};
    end
  end

  assign flags = r_flags;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, directed handshake/reset sequences and random
// transactions against a plain-arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  opcode = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] C;
  logic        ERR_out;
`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0]  flags;
`endif

  int n_checks = 0;
  int n_err    = 0;

  alu_seq #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .ERR_out   (ERR_out)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: unsigned arithmetic straight from the opcode definitions
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic e);
    logic [63:0] wide;
    logic [4:0]  sh;
    sh = b[4:0];
    c = '0;
    e = 1'b0;
    case (op)
      4'h1: begin wide = 64'(a) + 64'(b); c = wide[31:0]; e = (wide > 64'hFFFF_FFFF); end
      4'h2: begin c = a - b; e = (a < b); end
      4'h3: begin wide = 64'(a) * 64'(b); c = wide[31:0]; e = ((wide >> 32) != 0); end
      4'h4: if (b == 0) begin c = 32'hFFFF_FFFF; e = 1'b1; end else c = a / b;
      4'h5: if (b == 0) begin c = a; e = 1'b1; end else c = a % b;
      4'h6: c = a & b;
      4'h7: c = a | b;
      4'h8: c = a ^ b;
      4'h9: c = ~a;
      4'hA: c = ~(a & b);
      4'hB: c = ~(a | b);
      4'hC: c = ~(a ^ b);
      4'hD: c = a << sh;
      4'hE: c = a >> sh;
      default: begin c = '0; e = 1'b1; end
    endcase
  endfunction

  // One transaction: present, accept, scramble inputs, wait for the result.
  // lat counts clock edges from the accept edge (inclusive) to out_valid.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] c, output logic e, output int lat, output int rdy_hi);
    int w;
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    opcode   = 4'($urandom);
    lat    = 1;
    rdy_hi = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    c = C;
    e = ERR_out;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] c, ec;
    logic        e, ee;
    int          lat, rdy_hi, stray;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [3:0]  b2b_op[3];
    logic [31:0] b2b_a[3], b2b_b[3], b2b_c[3];

    vt[0]  = '{4'h1, 32'h10,        32'h20,        32'h30,        1'b0, 1};
    vt[1]  = '{4'h1, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1};
    vt[2]  = '{4'h4, 32'h64,        32'h7,         32'hE,         1'b0, 33};
    vt[3]  = '{4'h5, 32'h64,        32'h7,         32'h2,         1'b0, 33};
    vt[4]  = '{4'h4, 32'h5,         32'h0,         32'hFFFF_FFFF, 1'b1, 1};
    vt[5]  = '{4'h3, 32'h10,        32'h10,        32'h100,       1'b0, 1};
    vt[6]  = '{4'h3, 32'h1_0000,    32'h1_0000,    32'h0,         1'b1, 1};
    vt[7]  = '{4'hD, 32'h1,         32'd31,        32'h8000_0000, 1'b0, 1};
    vt[8]  = '{4'hE, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1};
    vt[9]  = '{4'h0, 32'h12,        32'h34,        32'h0,         1'b1, 1};
    vt[10] = '{4'hF, 32'h12,        32'h34,        32'h0,         1'b1, 1};
    vt[11] = '{4'h2, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b1, 1};
    vt[12] = '{4'h5, 32'h7,         32'h0,         32'h7,         1'b1, 1};
    vt[13] = '{4'h9, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 1'b0, 1};
    vt[14] = '{4'hD, 32'h3,         32'h21,        32'h6,         1'b0, 1};
    vt[15] = '{4'h4, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1'b0, 33};
    vt[16] = '{4'h5, 32'hFFFF_FFFF, 32'h10,        32'hF,         1'b0, 33};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_C",         64'(C),         64'd0);
    check("reset_ERR",       64'(ERR_out),   64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 17; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, c, e, lat, rdy_hi);
      check($sformatf("vec%0d_C", i),   64'(c),      64'(vt[i].c));
      check($sformatf("vec%0d_ERR", i), 64'(e),      64'(vt[i].e));
      check($sformatf("vec%0d_lat", i), 64'(lat),    64'(vt[i].lat));
      check($sformatf("vec%0d_busy_ready", i), 64'(rdy_hi), 64'd0);
    end
    @(posedge clk); #1;
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: XOR result held while a NAND waits
    out_ready = 1'b0;
    do_op("bp_xor", 4'h8, 32'hFF, 32'hFF00, c, e, lat, rdy_hi);
    check("bp_xor_C", 64'(c), 64'hFFFF);
    check("bp_xor_ERR", 64'(e), 64'd0);
    in_valid = 1'b1;
    opcode   = 4'hA;
    A        = 32'h0;
    B        = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_C", k),        64'(C),         64'hFFFF);
      check($sformatf("bp_hold%0d_valid", k),    64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_nand_valid", 64'(out_valid), 64'd1);
    check("bp_nand_C",     64'(C),         64'hFFFF_FFFF);
    check("bp_nand_ERR",   64'(ERR_out),   64'd0);
    @(posedge clk); #1;
    check("bp_no_dup", 64'(out_valid), 64'd0);

    // Back-to-back single-cycle ops, one result per cycle
    b2b_op[0] = 4'h6; b2b_a[0] = 32'hFF00; b2b_b[0] = 32'h00FF; b2b_c[0] = 32'h0;
    b2b_op[1] = 4'h7; b2b_a[1] = 32'hFF00; b2b_b[1] = 32'h00FF; b2b_c[1] = 32'hFFFF;
    b2b_op[2] = 4'hC; b2b_a[2] = 32'hFFFF; b2b_b[2] = 32'h0;    b2b_c[2] = 32'hFFFF_0000;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      opcode   = b2b_op[k];
      A        = b2b_a[k];
      B        = b2b_b[k];
      #1;
      check($sformatf("b2b%0d_in_ready", k), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      check($sformatf("b2b%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("b2b%0d_C", k),     64'(C),         64'(b2b_c[k]));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset during a divide aborts it
    in_valid = 1'b1;
    opcode   = 4'h4;
    A        = 32'h64;
    B        = 32'h7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_div_valid",    64'(out_valid), 64'd0);
    check("rst_div_C",        64'(C),         64'd0);
    check("rst_div_ERR",      64'(ERR_out),   64'd0);
    check("rst_div_in_ready", 64'(in_ready),  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    check("rst_div_no_result", 64'(stray), 64'd0);
    do_op("post_rst_add", 4'h1, 32'h1, 32'h1, c, e, lat, rdy_hi);
    check("post_rst_add_C",   64'(c),   64'd2);
    check("post_rst_add_ERR", 64'(e),   64'd0);
    check("post_rst_add_lat", 64'(lat), 64'd1);

    // Random transactions against the reference model
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 40));
        1:       b = 32'h0;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255));
      ref_alu(op, a, b, ec, ee);
      do_op($sformatf("rnd%0d", n), op, a, b, c, e, lat, rdy_hi);
      check($sformatf("rnd%0d_op%0h_C", n, op),   64'(c), 64'(ec));
      check($sformatf("rnd%0d_op%0h_ERR", n, op), 64'(e), 64'(ee));
      check($sformatf("rnd%0d_op%0h_lat", n, op), 64'(lat),
            ((op == 4'h4 || op == 4'h5) && b != 0) ? 64'd33 : 64'd1);
    end
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
